// File: rtl/seven_seg_serial_driver.sv
// seven_seg_serial_driver
//   Captures a binary value on start, converts it to BCD with a sequential
//   double-dabble engine, encodes each digit to a segment byte and shifts the
//   bytes out MSB-first to a chain of 74HC595-style shift registers, then
//   pulses the storage latch.
//
//   Optional build macro: SEVSEG_LZ_BLANK_EN
//     defined   -> leading zero digits are sent as 0x00 (LS digit always shown)
//     undefined -> every digit is shown, leading zeros as 0x3F
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   bin        in   [BIN_W-1:0] value to display, sampled on accepted start
//   start      in   request an update; accepted only while busy=0
//   busy       out  high from accepted start until done
//   done       out  one-cycle pulse after the latch has been issued
//   seg_data   out  serial segment data
//   seg_clk    out  chain shift clock
//   seg_latch  out  chain storage latch
//
// state   | meaning
// IDLE    | waiting for start
// CONVERT | BIN_W double-dabble steps
// SHIFT   | DIGITS*8 bits, each CLK_DIV low + CLK_DIV high seg_clk cycles
// LATCH   | seg_latch high for CLK_DIV cycles

module seven_seg_serial_driver #(
  parameter int BIN_W   = 17,
  parameter int DIGITS  = 6,
  parameter int CLK_DIV = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BIN_W-1:0] bin,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             seg_data,
  output logic             seg_clk,
  output logic             seg_latch
);

  localparam int DW  = 4 * DIGITS;
  localparam int SW  = 8 * DIGITS;
  localparam int CW  = $clog2(BIN_W + 1);
  localparam int BW  = $clog2(SW + 1);
  localparam int DVW = $clog2(CLK_DIV + 1);

  typedef enum logic [1:0] {IDLE, CONVERT, SHIFT, LATCH} state_t;

  state_t           state;
  logic [BIN_W-1:0] bin_sh;
  logic [DW-1:0]    bcd;
  logic [SW-1:0]    sh_reg;
  logic [CW-1:0]    conv_cnt;
  logic [BW-1:0]    bit_cnt;
  logic [DVW-1:0]   div_cnt;
  logic             phase;      // 0: seg_clk low half, 1: high half

  logic [DW-1:0]    bcd_adj;
  logic [DW-1:0]    bcd_nxt;
  logic [BIN_W-1:0] bin_nxt;
  logic [SW-1:0]    enc_nxt;

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 8'h3F;
      4'd1:    seg_code = 8'h06;
      4'd2:    seg_code = 8'h5B;
      4'd3:    seg_code = 8'h4F;
      4'd4:    seg_code = 8'h66;
      4'd5:    seg_code = 8'h6D;
      4'd6:    seg_code = 8'h7D;
      4'd7:    seg_code = 8'h07;
      4'd8:    seg_code = 8'h7F;
      4'd9:    seg_code = 8'h6F;
      default: seg_code = 8'h00;
    endcase
  endfunction

  function automatic logic [SW-1:0] encode(input logic [DW-1:0] b);
    logic [SW-1:0] enc;
    logic          seen;
    enc  = '0;
    seen = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
`ifdef SEVSEG_LZ_BLANK_EN
      // blank until the first nonzero digit; units digit is always shown
      if (b[4*i +: 4] != 4'd0 || i == 0) seen = 1'b1;
      enc[8*i +: 8] = seen ? seg_code(b[4*i +: 4]) : 8'h00;
`else
      seen = 1'b1;
      enc[8*i +: 8] = seg_code(b[4*i +: 4]);
`endif
    end
    return enc;
  endfunction

  // One double-dabble step; the carry out of the top digit falls off.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    {bcd_nxt, bin_nxt} = {bcd_adj[DW-2:0], bin_sh, 1'b0};
    enc_nxt = encode(bcd_nxt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bin_sh    <= '0;
      bcd       <= '0;
      sh_reg    <= '0;
      conv_cnt  <= '0;
      bit_cnt   <= '0;
      div_cnt   <= '0;
      phase     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      seg_data  <= 1'b0;
      seg_clk   <= 1'b0;
      seg_latch <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          seg_data  <= 1'b0;
          seg_clk   <= 1'b0;
          seg_latch <= 1'b0;
          if (start) begin
            bin_sh   <= bin;
            bcd      <= '0;
            conv_cnt <= CW'(BIN_W - 1);
            busy     <= 1'b1;
            state    <= CONVERT;
          end
        end

        CONVERT: begin
          bcd    <= bcd_nxt;
          bin_sh <= bin_nxt;
          if (conv_cnt == '0) begin
            // last step: load the encoded frame and present its first bit
            sh_reg   <= enc_nxt;
            seg_data <= enc_nxt[SW-1];
            seg_clk  <= 1'b0;
            phase    <= 1'b0;
            div_cnt  <= DVW'(CLK_DIV - 1);
            bit_cnt  <= BW'(SW - 1);
            state    <= SHIFT;
          end else begin
            conv_cnt <= conv_cnt - 1'b1;
          end
        end

        SHIFT: begin
          if (div_cnt != '0) begin
            div_cnt <= div_cnt - 1'b1;
          end else if (!phase) begin
            phase   <= 1'b1;
            seg_clk <= 1'b1;
            div_cnt <= DVW'(CLK_DIV - 1);
          end else if (bit_cnt == '0) begin
            seg_clk   <= 1'b0;
            seg_data  <= 1'b0;
            seg_latch <= 1'b1;
            div_cnt   <= DVW'(CLK_DIV - 1);
            state     <= LATCH;
          end else begin
            sh_reg   <= sh_reg << 1;
            seg_data <= sh_reg[SW-2];
            seg_clk  <= 1'b0;
            phase    <= 1'b0;
            div_cnt  <= DVW'(CLK_DIV - 1);
            bit_cnt  <= bit_cnt - 1'b1;
          end
        end

        LATCH: begin
          if (div_cnt != '0) begin
            div_cnt <= div_cnt - 1'b1;
          end else begin
            seg_latch <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seven_seg_serial_driver.sv
module tb_seven_seg_serial_driver;

  localparam int BIN_W   = 17;
  localparam int DIGITS  = 6;
  localparam int CLK_DIV = 2;
  localparam int LAT     = BIN_W + 16 * DIGITS * CLK_DIV + CLK_DIV;
  localparam int NBITS   = 8 * DIGITS;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [BIN_W-1:0] bin = '0;
  logic             start = 1'b0;
  logic             busy, done, seg_data, seg_clk, seg_latch;

  seven_seg_serial_driver #(.BIN_W(BIN_W), .DIGITS(DIGITS), .CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .bin(bin), .start(start), .busy(busy), .done(done),
    .seg_data(seg_data), .seg_clk(seg_clk), .seg_latch(seg_latch)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] seg_tbl [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                               8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic push_exp(input int unsigned v);
    int unsigned r;
    int unsigned modv;
    int d[DIGITS];
    bit seen;
    logic [7:0] b;
    modv = 1;
    for (int i = 0; i < DIGITS; i++) modv = modv * 10;
    r = v % modv;
    for (int i = 0; i < DIGITS; i++) begin
      d[i] = int'(r % 10);
      r = r / 10;
    end
    seen = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
`ifdef SEVSEG_LZ_BLANK_EN
      if (d[i] != 0 || i == 0) seen = 1'b1;
      b = seen ? seg_tbl[d[i]] : 8'h00;
`else
      b = seg_tbl[d[i]];
`endif
      exp_q.push_back(b);
    end
  endtask

  // Monitor: capture seg_data on each seg_clk rise, compare bytes in order.
  int   rise_cnt = 0;
  int   latch_cyc = 0;
  int   done_cnt = 0;
  logic prev_clk = 1'b0;
  logic [7:0] acc = '0;
  int   nb = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_clk = 1'b0;
      nb = 0;
      acc = '0;
    end else begin
      if (seg_clk && !prev_clk) begin
        rise_cnt++;
        acc = {acc[6:0], seg_data};
        nb++;
        if (nb == 8) begin
          nb = 0;
          if (exp_q.size() == 0) chk("sb_empty", 32'(exp_q.size()), 32'd1);
          else chk("byte", {24'd0, acc}, {24'd0, exp_q.pop_front()});
        end
      end
      if (seg_latch) latch_cyc++;
      if (done) done_cnt++;
      prev_clk = seg_clk;
    end
  end

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < LAT + 50) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic run_frame(input int unsigned v);
    int cyc, r0, l0, d0;
    r0 = rise_cnt; l0 = latch_cyc; d0 = done_cnt;
    bin = BIN_W'(v);
    start = 1'b1;
    push_exp(v);
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_set", 32'(busy), 32'd1);
    wait_done(cyc);
    chk("latency", 32'(cyc), 32'(LAT));
    @(posedge clk); #1;
    chk("done_pulse", 32'(done), 32'd0);
    chk("busy_clr", 32'(busy), 32'd0);
    chk("clk_rises", 32'(rise_cnt - r0), 32'(NBITS));
    chk("latch_len", 32'(latch_cyc - l0), 32'(CLK_DIV));
    chk("done_cnt", 32'(done_cnt - d0), 32'd1);
    chk("q_left", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int cyc, r0, l0, d0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", {27'd0, busy, done, seg_data, seg_clk, seg_latch}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // basic frames and boundary values
    run_frame(12345);
    run_frame(0);
    run_frame(131071);
    run_frame(9);
    run_frame(100000);
    for (int k = 0; k < 3; k++) run_frame($urandom_range(0, (1 << BIN_W) - 1));

    // start re-pulsed while busy, bin changing: ignored
    d0 = done_cnt;
    bin = BIN_W'(54321);
    start = 1'b1;
    push_exp(54321);
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < LAT + 50) begin
      if (cyc == 4 || cyc == 99) begin
        start = 1'b1;
        bin = BIN_W'($urandom_range(0, (1 << BIN_W) - 1));
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    chk("busy_ignore_lat", 32'(cyc), 32'(LAT));
    repeat (LAT + 10) @(posedge clk);
    #1;
    chk("busy_ignore_done", 32'(done_cnt - d0), 32'd1);
    chk("q_left", 32'(exp_q.size()), 32'd0);

    // reset mid-SHIFT aborts the frame
    bin = BIN_W'(777777 % (1 << BIN_W));
    start = 1'b1;
    push_exp(777777 % (1 << BIN_W));
    @(posedge clk); #1;
    start = 1'b0;
    repeat (59) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_out", {27'd0, busy, done, seg_data, seg_clk, seg_latch}, 32'd0);
    exp_q.delete();
    l0 = latch_cyc; d0 = done_cnt;
    repeat (4) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (LAT + 20) @(posedge clk);
    #1;
    chk("abort_latch", 32'(latch_cyc - l0), 32'd0);
    chk("abort_done", 32'(done_cnt - d0), 32'd0);
    run_frame(9);

    // start held high: back-to-back frames
    d0 = done_cnt;
    bin = BIN_W'(24680);
    start = 1'b1;
    push_exp(24680);
    @(posedge clk); #1;
    for (int f = 0; f < 3; f++) begin
      r0 = rise_cnt; l0 = latch_cyc;
      wait_done(cyc);
      chk("b2b_latency", 32'(cyc), 32'(LAT));
      chk("b2b_rises", 32'(rise_cnt - r0), 32'(NBITS));
      chk("b2b_latch", 32'(latch_cyc - l0), 32'(CLK_DIV));
      if (f < 2) begin
        bin = BIN_W'(13579 + f * 11111);
        push_exp(13579 + f * 11111);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      chk("b2b_busy", 32'(busy), (f < 2) ? 32'd1 : 32'd0);
    end
    repeat (5) @(posedge clk);
    #1;
    chk("b2b_done_cnt", 32'(done_cnt - d0), 32'd3);
    chk("q_final", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
